// File: rtl/complex_block_accumulator_pkg.sv
// Shared types and width helpers for the complex block accumulator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package complex_block_accumulator_pkg;

    // Default component width of the FFT datapath sample
    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Accumulator width that cannot wrap for any block of up to max_len samples
    function automatic int acc_width(input int data_w, input int max_len);
        return data_w + $clog2(max_len);
    endfunction

    // Width able to hold block lengths 0..max_len inclusive
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/complex_block_accumulator_round_sat.sv
// One component: optional round-half-up right shift, then saturate to OUT_W.
// Latency: combinational.
// Backpressure: none (pure function of the input).
module complex_block_accumulator_round_sat #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic        [OUT_W-1:0] o_val,
    output logic                    o_sat
);

    // Half an output LSB; zero when there is no shift so the sum passes through exactly
    localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
    localparam logic signed [IN_W:0] W_RND = (IN_W+1)'(RND_I);
    localparam logic signed [IN_W:0] W_MAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] W_MIN = ~W_MAX;

    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_shf;

    // One guard bit so the rounding constant can never wrap the sum
    assign w_ext = {i_val[IN_W-1], i_val} + W_RND;
    assign w_shf = w_ext >>> SHIFT;

    // Clamp to the signed OUT_W range and flag any clipping
    always_comb begin
        o_sat = 1'b0;
        o_val = w_shf[OUT_W-1:0];
        if (w_shf > W_MAX) begin
            o_sat = 1'b1;
            o_val = W_MAX[OUT_W-1:0];
        end else if (w_shf < W_MIN) begin
            o_sat = 1'b1;
            o_val = W_MIN[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/complex_block_accumulator.sv
// Integrate-and-dump of N complex samples; emits one scaled, rounded, saturated sum per block.
// Latency: result valid the cycle after the last sample of a block is accepted.
// Backpressure: in_ready drops only while a result is held and out_ready is low.
module complex_block_accumulator
    import complex_block_accumulator_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int MAX_LEN = 256,
    parameter  int SHIFT   = 0,
    localparam int ACC_W   = acc_width(DATA_W, MAX_LEN),
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [LEN_W-1:0]    i_acc_len,
    input  logic                i_clear,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [2*DATA_W-1:0] i_in_data,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [2*DATA_W-1:0] o_out_data,
    output logic                o_out_sat
);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [LEN_W-1:0]         r_cnt;
    logic [LEN_W-1:0]         r_len_q;
    logic [LEN_W-1:0]         w_len_eff;
    logic signed [ACC_W-1:0]  r_acc_re;
    logic signed [ACC_W-1:0]  r_acc_im;
    logic signed [ACC_W-1:0]  w_smp_re;
    logic signed [ACC_W-1:0]  w_smp_im;
    logic signed [ACC_W-1:0]  w_base_re;
    logic signed [ACC_W-1:0]  w_base_im;
    logic signed [ACC_W-1:0]  w_sum_re;
    logic signed [ACC_W-1:0]  w_sum_im;
    logic                     r_out_valid;
    logic                     r_out_sat;
    logic [2*DATA_W-1:0]      r_out_data;
    logic [DATA_W-1:0]        w_res_re;
    logic [DATA_W-1:0]        w_res_im;
    logic                     w_sat_re;
    logic                     w_sat_im;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_last;

    // Input stalls only while a finished result is still waiting for the consumer
    assign w_in_ready = !(r_out_valid && !i_out_ready);
    // clear wins over a same-cycle sample, which is simply dropped
    assign w_accept   = i_in_valid && w_in_ready && !i_clear;

    // Length is latched at the start of a block; zero is treated as a length of one
    assign w_len_eff = (r_state == S_IDLE)
                     ? ((i_acc_len == '0) ? LEN_W'(1) : i_acc_len)
                     : r_len_q;
    assign w_last    = w_accept && (r_cnt == w_len_eff - LEN_W'(1));

    assign w_smp_re  = ACC_W'($signed(i_in_data[2*DATA_W-1:DATA_W]));
    assign w_smp_im  = ACC_W'($signed(i_in_data[DATA_W-1:0]));
    // First sample of a block starts from zero rather than from the stale accumulator
    assign w_base_re = (r_state == S_IDLE) ? '0 : r_acc_re;
    assign w_base_im = (r_state == S_IDLE) ? '0 : r_acc_im;
    assign w_sum_re  = w_base_re + w_smp_re;
    assign w_sum_im  = w_base_im + w_smp_im;

    complex_block_accumulator_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (SHIFT)
    ) u_rs_re (
        .i_val (w_sum_re),
        .o_val (w_res_re),
        .o_sat (w_sat_re)
    );

    complex_block_accumulator_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (SHIFT)
    ) u_rs_im (
        .i_val (w_sum_im),
        .o_val (w_res_im),
        .o_sat (w_sat_im)
    );

    // Block state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enter ACCUM on a non-final first sample; leave on the final sample or an abort
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_last) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (i_clear || w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sample counter, latched length and running sums
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_len_q  <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (w_accept) begin
            r_cnt    <= w_last ? '0 : r_cnt + LEN_W'(1);
            r_acc_re <= w_sum_re;
            r_acc_im <= w_sum_im;
            if (r_state == S_IDLE) begin
                r_len_q <= w_len_eff;
            end
        end
    end

    // Result register: a new result overrides a same-cycle drain so valid stays high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_res_re, w_res_im};
            r_out_sat   <= w_sat_re | w_sat_im;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Lengths beyond MAX_LEN would overrun the accumulator headroom
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_accept && (r_state == S_IDLE)) begin
            assert (i_acc_len <= LEN_W'(MAX_LEN));
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sat   = r_out_sat;

endmodule
